// File: rtl/mod_reduce_pkg.sv
// rtl/mod_reduce_pkg.sv - modulus constants and Barrett helpers shared by reduction/NTT blocks
package mod_reduce_pkg;

   localparam int              DIL_K  = 23;
   localparam longint unsigned DIL_Q  = 64'd8380417;
   localparam longint unsigned DIL_MU = 64'd8396807;

   localparam int              KYB_K  = 12;
   localparam longint unsigned KYB_Q  = 64'd3329;
   localparam longint unsigned KYB_MU = 64'd5039;

   function automatic longint unsigned calc_mu(input int k, input longint unsigned q);
      return (64'd1 << (2 * k)) / q;
   endfunction

   // Barrett with a single conditional-subtract stage only holds for 2^(K-1) < Q < 2^K.
   function automatic bit barrett_params_ok(input int k, input int data_width,
                                            input longint unsigned q, input longint unsigned mu);
      return (data_width == 2 * k) &&
             (q > (64'd1 << (k - 1))) &&
             (q < (64'd1 << k)) &&
             (mu == calc_mu(k, q));
   endfunction

endpackage

// File: rtl/barrett_reduce_pipe_if.sv
// rtl/barrett_reduce_pipe_if.sv - input/output stream handshake bundle of the Barrett reducer
interface barrett_reduce_pipe_if #(
   parameter int DATA_WIDTH = 46,
   parameter int Q_WIDTH    = 23,
   parameter int TAG_WIDTH  = 8
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] data_in;
   logic [TAG_WIDTH-1:0]  tag_in;
   logic                  out_valid;
   logic                  out_ready;
   logic [Q_WIDTH-1:0]    data_out;
   logic [TAG_WIDTH-1:0]  tag_out;
   logic                  busy;

   modport master (
      output in_valid, data_in, tag_in, out_ready,
      input  in_ready, out_valid, data_out, tag_out, busy
   );

   modport slave (
      input  in_valid, data_in, tag_in, out_ready,
      output in_ready, out_valid, data_out, tag_out, busy
   );
endinterface

// File: rtl/mod_cond_sub2.sv
// rtl/mod_cond_sub2.sv - combinational r mod Q for r < 3Q via at most one of two subtractions
module mod_cond_sub2 #(
   parameter int W = 23
) (
   input  logic [W+1:0] i_r,
   input  logic [W+1:0] i_q,
   output logic [W-1:0] o_res
);
   logic [W+1:0] w_2q;
   logic [W+1:0] w_sel;

   // 3Q < 2^(W+2) because Q < 2^W, so both candidates fit without overflow.
   assign w_2q = i_q << 1;

   always_comb begin
      w_sel = i_r;
      if (i_r >= w_2q) begin
         w_sel = i_r - w_2q;
      end else if (i_r >= i_q) begin
         w_sel = i_r - i_q;
      end
   end

   assign o_res = W'(w_sel);
endmodule

// File: rtl/barrett_reduce_pipe.sv
// rtl/barrett_reduce_pipe.sv - 4-stage stallable Barrett reduction x mod Q with sideband tag
module barrett_reduce_pipe
   import mod_reduce_pkg::*;
#(
   parameter int              Q_WIDTH    = 23,
   parameter longint unsigned Q          = 64'd8380417,
   parameter int              DATA_WIDTH = 46,
   parameter longint unsigned MU         = 64'd8396807,
   parameter int              TAG_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   barrett_reduce_pipe_if.slave  bus
);
   localparam int K  = Q_WIDTH;
   localparam int PW = 2 * K + 2;
   localparam int RW = K + 2;

   localparam logic [K:0]    MU_C = (K + 1)'(MU);
   localparam logic [RW-1:0] Q_C  = RW'(Q);

   if (!barrett_params_ok(K, DATA_WIDTH, Q, MU)) begin : g_param_check
      $error("barrett_reduce_pipe: inconsistent Q, Q_WIDTH, DATA_WIDTH or MU");
   end

   logic                 w_advance;
   logic [K:0]           w_q1;
   logic [PW-1:0]        w_p;
   logic [K:0]           w_q3;
   logic [RW-1:0]        w_m;
   logic [RW-1:0]        w_r;
   logic [K-1:0]         w_res;

   logic                 r_s1_valid;
   logic [PW-1:0]        r_s1_p;
   logic [RW-1:0]        r_s1_xl;
   logic [TAG_WIDTH-1:0] r_s1_tag;

   logic                 r_s2_valid;
   logic [RW-1:0]        r_s2_m;
   logic [RW-1:0]        r_s2_xl;
   logic [TAG_WIDTH-1:0] r_s2_tag;

   logic                 r_s3_valid;
   logic [RW-1:0]        r_s3_r;
   logic [TAG_WIDTH-1:0] r_s3_tag;

   logic                 r_s4_valid;
   logic [K-1:0]         r_s4_data;
   logic [TAG_WIDTH-1:0] r_s4_tag;

   // The whole pipe moves as one; only the output beat can block it.
   assign w_advance = !r_s4_valid || bus.out_ready;

   assign w_q1 = (K + 1)'(bus.data_in >> (K - 1));
   assign w_p  = PW'(w_q1) * PW'(MU_C);
   assign w_q3 = (K + 1)'(r_s1_p >> (K + 1));

   // Only the low K+2 bits of x and q3*Q matter: the true remainder is below 3Q < 2^(K+2).
   assign w_m  = RW'(w_q3) * Q_C;
   assign w_r  = r_s2_xl - r_s2_m;

   mod_cond_sub2 #(
      .W(K)
   ) u_cond_sub2 (
      .i_r  (r_s3_r),
      .i_q  (Q_C),
      .o_res(w_res)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s2_valid <= 1'b0;
         r_s3_valid <= 1'b0;
         r_s4_valid <= 1'b0;
         r_s4_data  <= '0;
         r_s4_tag   <= '0;
      end else if (w_advance) begin
         r_s1_valid <= bus.in_valid;
         r_s2_valid <= r_s1_valid;
         r_s3_valid <= r_s2_valid;
         r_s4_valid <= r_s3_valid;
         r_s4_data  <= w_res;
         r_s4_tag   <= r_s3_tag;
      end
   end

   // Datapath needs no reset: bubbles carry don't-care payload behind a cleared valid.
   always_ff @(posedge clk) begin
      if (w_advance) begin
         r_s1_p   <= w_p;
         r_s1_xl  <= RW'(bus.data_in);
         r_s1_tag <= bus.tag_in;
         r_s2_m   <= w_m;
         r_s2_xl  <= r_s1_xl;
         r_s2_tag <= r_s1_tag;
         r_s3_r   <= w_r;
         r_s3_tag <= r_s2_tag;
      end
   end

   assign bus.in_ready  = w_advance;
   assign bus.out_valid = r_s4_valid;
   assign bus.data_out  = r_s4_data;
   assign bus.tag_out   = r_s4_tag;
   assign bus.busy      = r_s1_valid | r_s2_valid | r_s3_valid | r_s4_valid;
endmodule

// File: tb/tb_barrett_reduce_pipe.sv
// tb/tb_barrett_reduce_pipe.sv - self-checking bench for barrett_reduce_pipe (Dilithium and Kyber)
module tb_barrett_reduce_pipe;

   localparam longint unsigned DQ     = 64'd8380417;
   localparam longint unsigned X_MASK = (64'd1 << 46) - 64'd1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   barrett_reduce_pipe_if #(.DATA_WIDTH(46), .Q_WIDTH(23), .TAG_WIDTH(8)) dif ();
   barrett_reduce_pipe_if #(.DATA_WIDTH(24), .Q_WIDTH(12), .TAG_WIDTH(8)) kif ();

   barrett_reduce_pipe #(
      .Q_WIDTH(23), .Q(64'd8380417), .DATA_WIDTH(46), .MU(64'd8396807), .TAG_WIDTH(8)
   ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (dif)
   );

   barrett_reduce_pipe #(
      .Q_WIDTH(12), .Q(64'd3329), .DATA_WIDTH(24), .MU(64'd5039), .TAG_WIDTH(8)
   ) u_dut_kyber (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (kif)
   );

   typedef struct {
      longint unsigned res;
      logic [7:0]      tag;
   } exp_t;

   int              n_checks = 0;
   int              n_fail   = 0;
   int              n_out    = 0;
   exp_t            sb_q[$];
   exp_t            mon_e;
   exp_t            mon_in;
   longint unsigned stim_x[$];
   logic [7:0]      stim_tag[$];
   bit              drive_done;

   longint unsigned t1_x[4]   = '{64'd0, 64'd8380417, 64'd16760839, 64'd70231372333056};
   longint unsigned t1_exp[4] = '{64'd0, 64'd0, 64'd5, 64'd1};
   longint unsigned ky_x[3]   = '{64'd11075584, 64'd3329, 64'd6657};
   longint unsigned ky_exp[3] = '{64'd1, 64'd0, 64'd3328};

   task automatic check_eq(input string tag, input longint unsigned got, input longint unsigned exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint unsigned rand_x();
      longint unsigned v;
      longint unsigned k;
      int              sel;
      v   = {$urandom, $urandom};
      v   = v & X_MASK;
      sel = $urandom_range(0, 9);
      k   = longint'($urandom_range(1, 8396807));
      case (sel)
         0:       v = X_MASK;
         1:       v = 64'd0;
         2:       v = k * DQ;
         3:       v = k * DQ - 64'd1;
         default: ;
      endcase
      return v;
   endfunction

   // Scoreboard: expected results are plain x mod Q, queued in acceptance order.
   always @(negedge clk) begin
      if (!rst_n) begin
         sb_q.delete();
      end else begin
         if (dif.out_valid && dif.out_ready) begin
            n_out++;
            if (sb_q.size() == 0) begin
               check_eq("sb_unexpected_beat", 1, 0);
            end else begin
               mon_e = sb_q.pop_front();
               check_eq("sb_data", longint'(dif.data_out), mon_e.res);
               check_eq("sb_tag", longint'(dif.tag_out), longint'(mon_e.tag));
            end
         end
         if (dif.in_valid && dif.in_ready) begin
            mon_in.res = longint'(dif.data_in) % DQ;
            mon_in.tag = dif.tag_in;
            sb_q.push_back(mon_in);
         end
      end
   end

   task automatic drive_stream(input int valid_pct);
      int idx   = 0;
      int guard = 0;
      bit hold  = 1'b0;
      while (idx < stim_x.size() && guard < 50000) begin
         @(posedge clk);
         #1;
         if (!hold) dif.in_valid = ($urandom_range(0, 99) < valid_pct);
         dif.data_in = 46'(stim_x[idx]);
         dif.tag_in  = stim_tag[idx];
         @(negedge clk);
         if (dif.in_valid && dif.in_ready) begin
            idx++;
            hold = 1'b0;
         end else begin
            hold = dif.in_valid;
         end
         guard++;
      end
      if (idx < stim_x.size()) check_eq("drive_timeout", idx, stim_x.size());
      @(posedge clk);
      #1;
      dif.in_valid = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      int g = 0;
      while ((sb_q.size() != 0 || dif.busy) && g < 2000) begin
         @(negedge clk);
         g++;
      end
      check_eq(tag, sb_q.size(), 0);
      check_eq({tag, "_busy"}, longint'(dif.busy), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int cnt;
      int kcnt;
      int g;
      dif.in_valid  = 1'b0;
      dif.data_in   = '0;
      dif.tag_in    = '0;
      dif.out_ready = 1'b1;
      kif.in_valid  = 1'b0;
      kif.data_in   = '0;
      kif.tag_in    = '0;
      kif.out_ready = 1'b1;

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_out_valid", longint'(dif.out_valid), 0);
      check_eq("rst_busy", longint'(dif.busy), 0);
      check_eq("rst_data_out", longint'(dif.data_out), 0);
      check_eq("rst_tag_out", longint'(dif.tag_out), 0);
      check_eq("rst_kyber_out_valid", longint'(kif.out_valid), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("in_ready_after_reset", longint'(dif.in_ready), 1);

      // Directed Dilithium vectors, back-to-back, exact 4-cycle latency.
      for (int c = 0; c < 9; c++) begin
         @(posedge clk);
         #1;
         dif.in_valid = (c < 4);
         dif.data_in  = (c < 4) ? 46'(t1_x[c]) : '0;
         dif.tag_in   = 8'(c + 16);
         @(negedge clk);
         if (c < 4) check_eq("t1_in_ready", longint'(dif.in_ready), 1);
         if (c >= 4 && c < 8) begin
            check_eq("t1_out_valid", longint'(dif.out_valid), 1);
            check_eq("t1_data", longint'(dif.data_out), t1_exp[c-4]);
         end else begin
            check_eq("t1_out_valid_low", longint'(dif.out_valid), 0);
         end
      end

      // Kyber instance.
      kcnt = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         kif.in_valid = (c < 3);
         if (c < 3) kif.data_in = 24'(ky_x[c]);
         else       kif.data_in = '0;
         @(negedge clk);
         if (kif.out_valid && kcnt < 3) begin
            check_eq("kyber_data", longint'(kif.data_out), ky_exp[kcnt]);
            kcnt++;
         end
      end
      check_eq("kyber_count", kcnt, 3);

      // Output stall of 3 cycles while the first of six beats is presented.
      stim_x.delete();
      stim_tag.delete();
      for (int i = 0; i < 6; i++) begin
         stim_x.push_back(rand_x());
         stim_tag.push_back(8'(i + 1));
      end
      base = n_out;
      @(posedge clk);
      #1;
      dif.out_ready = 1'b0;
      fork
         drive_stream(100);
         begin
            g = 0;
            while (!dif.out_valid && g < 30) begin
               @(negedge clk);
               g++;
            end
            check_eq("stall_first_valid", longint'(dif.out_valid), 1);
            check_eq("stall_first_tag", longint'(dif.tag_out), 1);
            for (int s = 0; s < 3; s++) begin
               check_eq("stall_in_ready", longint'(dif.in_ready), 0);
               check_eq("stall_hold_tag", longint'(dif.tag_out), 1);
               if (s < 2) @(negedge clk);
            end
            @(posedge clk);
            #1;
            dif.out_ready = 1'b1;
         end
      join
      wait_drain("stall_drain");
      check_eq("stall_count", n_out - base, 6);

      // Reset with three beats in flight.
      base = n_out;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         dif.in_valid = 1'b1;
         dif.data_in  = 46'(rand_x());
         dif.tag_in   = 8'(c + 40);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      dif.in_valid = 1'b0;
      rst_n        = 1'b0;
      @(negedge clk);
      check_eq("midrst_busy_before", longint'(dif.busy), 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("midrst_out_valid", longint'(dif.out_valid), 0);
      check_eq("midrst_busy", longint'(dif.busy), 0);
      check_eq("midrst_data_out", longint'(dif.data_out), 0);
      check_eq("midrst_tag_out", longint'(dif.tag_out), 0);
      cnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (dif.out_valid) cnt++;
      end
      check_eq("midrst_no_emit", cnt, 0);
      check_eq("midrst_no_transfer", n_out - base, 0);

      // Random traffic with random valid and backpressure.
      stim_x.delete();
      stim_tag.delete();
      for (int i = 0; i < 3000; i++) begin
         stim_x.push_back(rand_x());
         stim_tag.push_back(8'($urandom_range(0, 255)));
      end
      base       = n_out;
      drive_done = 1'b0;
      fork
         begin
            drive_stream(70);
            drive_done = 1'b1;
         end
         begin
            int rg = 0;
            while ((!drive_done || sb_q.size() != 0) && rg < 40000) begin
               @(posedge clk);
               #1;
               dif.out_ready = ($urandom_range(0, 3) != 0);
               rg++;
            end
            dif.out_ready = 1'b1;
         end
      join
      wait_drain("rand_drain");
      check_eq("rand_count", n_out - base, 3000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
